// File: rtl/perf_event_scheduler_pkg.sv
// Shared types and constants for the performance-event scheduler.
// Source index order doubles as the round-robin search order.
package perf_sched_pkg;

  typedef logic [1:0] src_idx_t;

  localparam int       NUM_SRC      = 3;
  localparam src_idx_t SRC_INSTR    = 2'd0;
  localparam src_idx_t SRC_MEM_ACC  = 2'd1;
  localparam src_idx_t SRC_MEM_CORR = 2'd2;

  localparam int PEND_W = 3;
  typedef logic [PEND_W-1:0] pend_t;
  localparam pend_t PEND_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_t;

  function automatic src_idx_t rr_next(input src_idx_t idx);
    return (idx == SRC_MEM_CORR) ? SRC_INSTR : src_idx_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/perf_event_scheduler_if.sv
// Pipeline-side bundle for the event scheduler; ovf_clr exists only with PERF_OVF_FLAG_EN.
// master = event producer / counter block side, slave = scheduler.
interface perf_event_scheduler_if;
  logic       count_en;
  logic       evt_instr;
  logic       evt_mem_acc;
  logic       evt_mem_corr;
  logic       drain_req;
  logic       Instruc_Count_Ex;
  logic       MEM_Acc_Ex;
  logic       MEM_Correct_Ex;
  logic       busy;
  logic       drain_done;
  logic [2:0] ovf_flags;
`ifdef PERF_OVF_FLAG_EN
  logic       ovf_clr;

  modport master (
    output count_en, evt_instr, evt_mem_acc, evt_mem_corr, drain_req, ovf_clr,
    input  Instruc_Count_Ex, MEM_Acc_Ex, MEM_Correct_Ex, busy, drain_done, ovf_flags
  );
  modport slave (
    input  count_en, evt_instr, evt_mem_acc, evt_mem_corr, drain_req, ovf_clr,
    output Instruc_Count_Ex, MEM_Acc_Ex, MEM_Correct_Ex, busy, drain_done, ovf_flags
  );
`else
  modport master (
    output count_en, evt_instr, evt_mem_acc, evt_mem_corr, drain_req,
    input  Instruc_Count_Ex, MEM_Acc_Ex, MEM_Correct_Ex, busy, drain_done, ovf_flags
  );
  modport slave (
    input  count_en, evt_instr, evt_mem_acc, evt_mem_corr, drain_req,
    output Instruc_Count_Ex, MEM_Acc_Ex, MEM_Correct_Ex, busy, drain_done, ovf_flags
  );
`endif
endinterface

// File: rtl/perf_event_scheduler_arb.sv
// Three-way round-robin arbiter: combinational one-hot grant, search starts after last winner.
// Pointer only moves on a grant; reset leaves mem_corr as last winner so instr goes first.
module rr_arbiter3
  import perf_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] i_req,
  output logic [NUM_SRC-1:0] o_gnt
);

  src_idx_t r_last;
  src_idx_t w_p0;
  src_idx_t w_p1;
  src_idx_t w_p2;
  src_idx_t w_gnt_idx;

  assign w_p0 = rr_next(r_last);
  assign w_p1 = rr_next(w_p0);
  assign w_p2 = rr_next(w_p1);

  always_comb begin
    o_gnt     = '0;
    w_gnt_idx = r_last;
    if (i_req[w_p0]) begin
      o_gnt[w_p0] = 1'b1;
      w_gnt_idx   = w_p0;
    end else if (i_req[w_p1]) begin
      o_gnt[w_p1] = 1'b1;
      w_gnt_idx   = w_p1;
    end else if (i_req[w_p2]) begin
      o_gnt[w_p2] = 1'b1;
      w_gnt_idx   = w_p2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= SRC_MEM_CORR;
    end else if (|i_req) begin
      r_last <= w_gnt_idx;
    end
  end

endmodule

// File: rtl/perf_event_scheduler.sv
// Per-source 0..7 pending counters drained one strobe per cycle (grant -> strobe next cycle), plus drain FSM.
// Events at a full counter with no same-cycle grant are dropped; PERF_OVF_FLAG_EN adds sticky drop flags.
module perf_event_scheduler
  import perf_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  perf_event_scheduler_if.slave  bus
);

  logic [NUM_SRC-1:0] w_evt;
  logic [NUM_SRC-1:0] w_acc;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_gnt;
  logic               w_busy;
  pend_t              r_pend [NUM_SRC];
  logic [NUM_SRC-1:0] r_strobe;
  drain_state_t       r_state;
  drain_state_t       w_state_nxt;

  always_comb begin
    w_evt               = '0;
    w_evt[SRC_INSTR]    = bus.evt_instr;
    w_evt[SRC_MEM_ACC]  = bus.evt_mem_acc;
    w_evt[SRC_MEM_CORR] = bus.evt_mem_corr;
  end

  assign w_acc = w_evt & {NUM_SRC{bus.count_en}};

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_req[i] = (r_pend[i] != '0);
    end
  end

  assign w_busy = |w_req;

  rr_arbiter3 u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  // Accept+grant on one source cancels out; accept at full with no grant is the drop case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_pend[i] <= '0;
      end
      r_strobe <= '0;
    end else begin
      r_strobe <= w_gnt;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_acc[i] && !w_gnt[i] && (r_pend[i] != PEND_MAX)) begin
          r_pend[i] <= r_pend[i] + 1'b1;
        end else if (!w_acc[i] && w_gnt[i]) begin
          r_pend[i] <= r_pend[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Empty counters imply no grant this cycle, so the final strobe is already out;
  // a same-cycle accepted event keeps the drain open.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.drain_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!w_busy && (w_acc == '0)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.Instruc_Count_Ex = r_strobe[SRC_INSTR];
  assign bus.MEM_Acc_Ex       = r_strobe[SRC_MEM_ACC];
  assign bus.MEM_Correct_Ex   = r_strobe[SRC_MEM_CORR];
  assign bus.busy             = w_busy;
  assign bus.drain_done       = (r_state == ST_DONE);

`ifdef PERF_OVF_FLAG_EN
  logic [NUM_SRC-1:0] w_drop;
  logic [NUM_SRC-1:0] r_ovf;

  always_comb begin
    w_drop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_drop[i] = w_acc[i] && !w_gnt[i] && (r_pend[i] == PEND_MAX);
    end
  end

  // A drop in the clear cycle wins so no overflow goes unreported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~{NUM_SRC{bus.ovf_clr}}) | w_drop;
    end
  end

  assign bus.ovf_flags = r_ovf;
`else
  assign bus.ovf_flags = '0;
`endif

endmodule

// File: tb/tb_perf_event_scheduler.sv
// Directed bench for perf_event_scheduler: per-cycle vector table plus saturation and reset-abort sequences.
module tb_perf_event_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  perf_event_scheduler_if bus_if ();

  perf_event_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic       en;
    logic [2:0] evt;   // {mem_corr, mem_acc, instr}
    logic       drq;
    logic [2:0] strb;  // {MEM_Correct_Ex, MEM_Acc_Ex, Instruc_Count_Ex}
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs [28];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] strobes();
    return {bus_if.MEM_Correct_Ex, bus_if.MEM_Acc_Ex, bus_if.Instruc_Count_Ex};
  endfunction

  task automatic drive(input logic en, input logic [2:0] evt, input logic drq);
    bus_if.count_en     = en;
    bus_if.evt_instr    = evt[0];
    bus_if.evt_mem_acc  = evt[1];
    bus_if.evt_mem_corr = evt[2];
    bus_if.drain_req    = drq;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_i;
    int cnt_a;
    int cnt_c;
    logic seen_done;
    logic seen_strb;

    //                en    evt     drq   strb    busy  done
    vecs[0]  = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 3'b000, 1'b0, 3'b100, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'b001, 1'b0, 3'b000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'b101, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'b001, 1'b0, 3'b000, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 3'b001, 1'b0, 3'b000, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 3'b001, 1'b1, 3'b001, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 3'b010, 1'b1, 3'b000, 1'b1, 1'b0};
    vecs[24] = '{1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0};
    vecs[25] = '{1'b1, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0};
    vecs[26] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[27] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0};

    reset = 1'b1;
    drive(1'b0, 3'b000, 1'b0);
`ifdef PERF_OVF_FLAG_EN
    bus_if.ovf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_strobes", 8'(strobes()), 8'h0);
    check("reset_busy", 8'(bus_if.busy), 8'h0);
    check("reset_done", 8'(bus_if.drain_done), 8'h0);
    check("reset_ovf", 8'(bus_if.ovf_flags), 8'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      drive(vecs[k].en, vecs[k].evt, vecs[k].drq);
      @(posedge clk);
      #1;
      if (strobes() !== vecs[k].strb) $display("  vector %0d strobe", k);
      check("vec_strobe", 8'(strobes()), 8'(vecs[k].strb));
      check("vec_busy", 8'(bus_if.busy), 8'(vecs[k].busy));
      check("vec_done", 8'(bus_if.drain_done), 8'(vecs[k].done));
    end

    // Saturation: all three sources for 9 cycles, then mem_corr alone for 3 more.
    do_reset();
    cnt_i = 0;
    cnt_a = 0;
    cnt_c = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      drive(1'b1, (c <= 9) ? 3'b111 : 3'b100, 1'b0);
      @(posedge clk);
      #1;
      check("sat_onehot", 8'($onehot0(strobes())), 8'h1);
      if (bus_if.Instruc_Count_Ex) cnt_i++;
      if (bus_if.MEM_Acc_Ex)       cnt_a++;
      if (bus_if.MEM_Correct_Ex)   cnt_c++;
      if (c == 10) check("ovf_before_drop", 8'(bus_if.ovf_flags), 8'h0);
`ifdef PERF_OVF_FLAG_EN
      if (c == 12) check("ovf_after_drop", 8'(bus_if.ovf_flags), 8'h4);
`else
      if (c == 12) check("ovf_after_drop", 8'(bus_if.ovf_flags), 8'h0);
`endif
    end
    @(negedge clk);
    drive(1'b1, 3'b000, 1'b0);
    // 17 entries remain (5+5+7); back-to-back strobes empty them in exactly 17 cycles.
    for (int c = 0; c < 17; c++) begin
      @(posedge clk);
      #1;
      check("drain_strobe_every_cycle", 8'($countones(strobes())), 8'h1);
      if (bus_if.Instruc_Count_Ex) cnt_i++;
      if (bus_if.MEM_Acc_Ex)       cnt_a++;
      if (bus_if.MEM_Correct_Ex)   cnt_c++;
    end
    check("sat_busy_empty", 8'(bus_if.busy), 8'h0);
    check("sat_cnt_instr", 8'(cnt_i), 8'd9);
    check("sat_cnt_mem_acc", 8'(cnt_a), 8'd9);
    check("sat_cnt_mem_corr", 8'(cnt_c), 8'd10);
    @(negedge clk);
`ifdef PERF_OVF_FLAG_EN
    check("ovf_held", 8'(bus_if.ovf_flags), 8'h4);
    bus_if.ovf_clr = 1'b1;
`endif
    @(posedge clk);
    #1;
    check("ovf_cleared", 8'(bus_if.ovf_flags), 8'h0);
    @(negedge clk);
`ifdef PERF_OVF_FLAG_EN
    bus_if.ovf_clr = 1'b0;
`endif

    // Reset asserted mid-drain: outputs clear at once and no drain_done follows.
    do_reset();
    @(negedge clk);
    drive(1'b1, 3'b111, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b111, 1'b1);
    @(negedge clk);
    drive(1'b1, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    check("pre_abort_strobe", 8'(strobes()), 8'h2);
    check("pre_abort_busy", 8'(bus_if.busy), 8'h1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_strobes", 8'(strobes()), 8'h0);
    check("abort_busy", 8'(bus_if.busy), 8'h0);
    check("abort_done", 8'(bus_if.drain_done), 8'h0);
    check("abort_ovf", 8'(bus_if.ovf_flags), 8'h0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    seen_strb = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus_if.drain_done) seen_done = 1'b1;
      if (strobes() != 3'b000) seen_strb = 1'b1;
    end
    check("abort_no_done", 8'(seen_done), 8'h0);
    check("abort_no_strobe", 8'(seen_strb), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_event_scheduler.md
PERF_EVENT_SCHEDULER -- requirements
Module: perf_event_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: count_en  in  1  event acceptance enable; events ignored while low.
REQ-004 SHALL have ports: evt_instr / evt_mem_acc / evt_mem_corr  in  1 each  single-cycle event pulses from the pipeline, any combination may coincide.
REQ-005 SHALL have ports: drain_req  in  1  request to flush all pending events.
REQ-006 SHALL have ports: Instruc_Count_Ex / MEM_Acc_Ex / MEM_Correct_Ex  out  1 each  registered increment strobes to the increment-register block.
REQ-007 SHALL have ports: busy  out  1  any pending count nonzero; drain_done  out  1  one-cycle drain-complete pulse.
REQ-008 SHALL have ports: ovf_flags  out  3  sticky per-source drop flags, bit0 instr, bit1 mem_acc, bit2 mem_corr; ovf_clr  in  1  clears them (PERF_OVF_FLAG_EN only).

Function
REQ-009 SHALL keep a 3-bit pending counter per source, range 0..7.
REQ-010 SHALL increment a source's counter on an accepted event (count_en=1), saturating at 7.
REQ-011 SHALL grant at most one source per cycle among sources with pending>0, round-robin: search starts at the source after the last granted (order instr -> mem_acc -> mem_corr -> instr).
REQ-012 SHALL, on grant in cycle N, decrement that counter and assert the matching strobe for exactly cycle N+1 (registered, one-hot or zero).
REQ-013 SHALL leave a counter unchanged when an accepted event and a grant hit the same source in the same cycle.
REQ-014 SHALL drop an accepted event arriving at pending=7 with no same-cycle grant for that source.
REQ-015 SHALL sustain one strobe per cycle while any counter is nonzero (no idle bubbles).
REQ-016 SHALL implement FSM IDLE, DRAIN, DONE: IDLE->DRAIN on drain_req; DRAIN->DONE when all counters 0 and no strobe outstanding; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL assert drain_done only in DONE; drain_req outside IDLE is ignored.
REQ-018 SHALL continue accepting events during DRAIN when count_en=1, extending DRAIN until empty.
REQ-019 SHALL set busy combinationally from counters (OR of nonzero).

Reset
REQ-020 SHALL on reset clear all counters, strobes, drain_done, ovf_flags; FSM to IDLE; round-robin pointer to "last granted = mem_corr" (instr highest priority).
REQ-021 SHALL abort a drain in progress on reset mid-operation, with no drain_done pulse.

Configuration
REQ-022 SHALL with PERF_OVF_FLAG_EN defined: set ovf_flags bit on each REQ-014 drop, hold until ovf_clr or reset; ovf_clr same cycle as a drop leaves the bit set.
REQ-023 SHALL without PERF_OVF_FLAG_EN: omit ovf_clr, tie ovf_flags to 0, drop silently.

Structure
REQ-024 SHALL place in package perf_sched_pkg: source indices (SRC_INSTR=0, SRC_MEM_ACC=1, SRC_MEM_CORR=2), PEND_W=3, PEND_MAX=7, FSM state type.
REQ-025 SHALL implement arbitration in sub-module rr_arbiter3 (3 requests, one-hot grant, internal last-grant pointer).

Verification
REQ-026 SHALL cover: single evt_instr after reset -> Instruc_Count_Ex high exactly 2 cycles after pulse edge, one cycle wide; busy high one cycle.
REQ-027 SHALL cover: all three events same cycle -> strobes instr, mem_acc, mem_corr in three consecutive cycles, then busy=0.
REQ-028 SHALL cover: 9 consecutive evt_mem_corr with other sources competing -> counter saturates, ovf_flags=3'b100 (with PERF_OVF_FLAG_EN), correct strobe count = 9 minus drops; ovf_clr -> 3'b000.
REQ-029 SHALL cover: 4 instr pending, drain_req -> 4 Instruc_Count_Ex strobes, drain_done pulse exactly one cycle after the last strobe, FSM back to IDLE.
REQ-030 SHALL cover: count_en=0 with events -> no strobes, busy=0; reset asserted mid-DRAIN -> all outputs 0 immediately, no drain_done.
